// File: rtl/rail_sequencer_pkg.sv
// Shared state encoding and helpers for the rail sequencer.
// The board top decodes state for LEDs, so it imports this package too.
package rail_sequencer_pkg;

    localparam int STATE_W = 4;

    localparam logic [3:0] ST_OFF       = 4'd0;
    localparam logic [3:0] ST_RAMP_UP   = 4'd1;
    localparam logic [3:0] ST_SETTLE    = 4'd2;
    localparam logic [3:0] ST_ON        = 4'd3;
    localparam logic [3:0] ST_RAMP_DOWN = 4'd4;
    localparam logic [3:0] ST_FAULT     = 4'd5;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/rail_sequencer_pg_filter.sv
// One rail's power-good path: 2-flop synchroniser followed by a debounce that
// accepts a new level only after PG_FILTER consecutive differing samples.
module rail_pg_filter #(
    parameter int PG_FILTER = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pg_i,
    output logic fpg_o
);
    localparam int CNT_W = (PG_FILTER > 1) ? $clog2(PG_FILTER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PG_FILTER - 1);

    logic             sync1_q, sync2_q, fpg_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            fpg_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pg_i;
            sync2_q <= sync1_q;
            // cnt_q counts how many differing samples preceded this one
            if (sync2_q == fpg_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                fpg_q <= sync2_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign fpg_o = fpg_q;

endmodule

// File: rtl/rail_sequencer.sv
// N-rail power sequencer: ordered power-up with settle, reverse power-down,
// immediate full shutdown on pg loss or ramp timeout. Define RAIL_SEQ_RETRY_EN for auto-retry.
module rail_sequencer
    import rail_sequencer_pkg::*;
#(
    parameter int NUM_RAILS   = 4,
    parameter int TIMER_W     = 16,
    parameter int PG_FILTER   = 8,
    parameter int PG_TIMEOUT  = 4000,
    parameter int SETTLE      = 400,
    parameter int OFF_DELAY   = 400,
    parameter int RETRY_DELAY = 40000,
    parameter int MAX_RETRIES = 3
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NUM_RAILS-1:0] pg,
    output logic [NUM_RAILS-1:0] en,
    output logic                 all_good,
    output logic                 fault,
    output logic [3:0]           fault_rail,
    output logic [STATE_W-1:0]   state
);
    localparam int STEP_W = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1;
    localparam logic [STEP_W-1:0]  LAST_STEP = STEP_W'(NUM_RAILS - 1);
    localparam logic [TIMER_W-1:0] T_TIMEOUT = TIMER_W'(PG_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] T_SETTLE  = TIMER_W'(SETTLE - 1);
    localparam logic [TIMER_W-1:0] T_OFF     = TIMER_W'(OFF_DELAY - 1);

    logic [STATE_W-1:0]   state_q, state_d;
    logic [STEP_W-1:0]    step_q, step_d, step_inc, step_dec;
    logic [TIMER_W-1:0]   timer_q, timer_d, timer_inc;
    logic [NUM_RAILS-1:0] en_q, en_d, fpg, accepted, failing;
    logic                 fault_q, fault_d;
    logic [3:0]           fault_rail_q, fault_rail_d;

`ifdef RAIL_SEQ_RETRY_EN
    localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [TIMER_W-1:0] T_RETRY   = TIMER_W'(RETRY_DELAY - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
    logic [RETRY_W-1:0] retries_q, retries_d;
`else
    logic unused_retry_cfg;
    assign unused_retry_cfg = ^{32'(RETRY_DELAY), 32'(MAX_RETRIES)};
`endif

    for (genvar i = 0; i < NUM_RAILS; i++) begin : g_pg
        rail_pg_filter #(.PG_FILTER(PG_FILTER)) u_filt (
            .clk_i (sysclk),
            .rst_i (reset),
            .pg_i  (pg[i]),
            .fpg_o (fpg[i])
        );
    end

    // Rails whose pg has already been accepted and must stay good.
    always_comb begin
        accepted = '0;
        for (int j = 0; j < NUM_RAILS; j++) begin
            if (state_q == ST_ON)
                accepted[j] = 1'b1;
            else if (state_q == ST_SETTLE && j <= int'(step_q))
                accepted[j] = 1'b1;
            else if (state_q == ST_RAMP_UP && j < int'(step_q))
                accepted[j] = 1'b1;
        end
    end

    assign failing   = accepted & ~fpg;
    assign step_inc  = step_q + 1'b1;
    assign step_dec  = step_q - 1'b1;
    assign timer_inc = (&timer_q) ? timer_q : timer_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        timer_d      = timer_inc;
        en_d         = en_q;
        fault_d      = fault_q;
        fault_rail_d = fault_rail_q;
`ifdef RAIL_SEQ_RETRY_EN
        retries_d    = retries_q;
`endif
        case (state_q)
            ST_OFF: begin
                timer_d = '0;
                if (enable) begin
                    en_d    = NUM_RAILS'(1);
                    step_d  = '0;
                    state_d = ST_RAMP_UP;
                end else begin
                    fault_d = 1'b0;
                end
            end
            ST_RAMP_UP, ST_SETTLE, ST_ON: begin
                if (|failing) begin
                    state_d      = ST_FAULT;
                    en_d         = '0;
                    fault_d      = 1'b1;
                    fault_rail_d = lowest_set(16'(failing));
                    timer_d      = '0;
                end else if (!enable) begin
                    state_d      = ST_RAMP_DOWN;
                    en_d[step_q] = 1'b0;
                    timer_d      = '0;
                end else if (state_q == ST_RAMP_UP) begin
                    if (fpg[step_q]) begin
                        state_d = ST_SETTLE;
                        timer_d = '0;
                    end else if (timer_q == T_TIMEOUT) begin
                        state_d      = ST_FAULT;
                        en_d         = '0;
                        fault_d      = 1'b1;
                        fault_rail_d = 4'(step_q);
                        timer_d      = '0;
                    end
                end else if (state_q == ST_SETTLE && timer_q == T_SETTLE) begin
                    timer_d = '0;
                    if (step_q == LAST_STEP) begin
                        state_d   = ST_ON;
                        fault_d   = 1'b0;
`ifdef RAIL_SEQ_RETRY_EN
                        retries_d = '0;
`endif
                    end else begin
                        step_d         = step_inc;
                        en_d[step_inc] = 1'b1;
                        state_d        = ST_RAMP_UP;
                    end
                end
            end
            ST_RAMP_DOWN: begin
                if (timer_q == T_OFF) begin
                    timer_d = '0;
                    if (step_q == '0) begin
                        state_d = ST_OFF;
                    end else begin
                        step_d         = step_dec;
                        en_d[step_dec] = 1'b0;
                    end
                end
            end
            ST_FAULT: begin
                en_d = '0;
                if (!enable) begin
                    state_d = ST_OFF;
                    fault_d = 1'b0;
                    timer_d = '0;
                end
`ifdef RAIL_SEQ_RETRY_EN
                else if (timer_q == T_RETRY && retries_q < RETRY_MAX) begin
                    retries_d = retries_q + 1'b1;
                    state_d   = ST_OFF;
                    timer_d   = '0;
                end
`endif
            end
            default: begin
                state_d = ST_OFF;
                en_d    = '0;
            end
        endcase
`ifdef RAIL_SEQ_RETRY_EN
        if (!enable) retries_d = '0;
`endif
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q      <= ST_OFF;
            step_q       <= '0;
            timer_q      <= '0;
            en_q         <= '0;
            fault_q      <= 1'b0;
            fault_rail_q <= 4'd0;
`ifdef RAIL_SEQ_RETRY_EN
            retries_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            timer_q      <= timer_d;
            en_q         <= en_d;
            fault_q      <= fault_d;
            fault_rail_q <= fault_rail_d;
`ifdef RAIL_SEQ_RETRY_EN
            retries_q    <= retries_d;
`endif
        end
    end

    assign en         = en_q;
    assign all_good   = (state_q == ST_ON);
    assign fault      = fault_q;
    assign fault_rail = fault_rail_q;
    assign state      = state_q;

endmodule

// File: tb/tb_rail_sequencer.sv
// Bench for rail_sequencer: directed scenarios plus randomized enable/pg/reset traffic,
// all outputs compared every cycle against a rail-count based behavioural model.
module tb_rail_sequencer;

    localparam int N  = 3;
    localparam int PF = 2;
    localparam int ST = 4;
    localparam int TO = 20;
    localparam int OD = 3;
    localparam int RD = 10;
    localparam int MR = 2;

    localparam int S_OFF = 0, S_RU = 1, S_SE = 2, S_ON = 3, S_RD = 4, S_FAULT = 5;

    logic         sysclk = 1'b0;
    logic         reset, enable;
    logic [N-1:0] pg;
    logic [N-1:0] en;
    logic         all_good, fault;
    logic [3:0]   fault_rail, state;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: rails counted as "how many are enabled", phase age in cycles.
    int m_state, m_on, m_age, m_frail, m_retries;
    bit m_fault;
    bit m_s1[N], m_s2[N], m_fpg[N];
    int m_hist[N];

    // Board: pg follows en after a per-rail delay, with optional forced-low glitches.
    int b_cnt[N], b_dly[N], b_glitch[N];

    rail_sequencer #(
        .NUM_RAILS(N), .TIMER_W(16), .PG_FILTER(PF), .PG_TIMEOUT(TO),
        .SETTLE(ST), .OFF_DELAY(OD), .RETRY_DELAY(RD), .MAX_RETRIES(MR)
    ) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .enable     (enable),
        .pg         (pg),
        .en         (en),
        .all_good   (all_good),
        .fault      (fault),
        .fault_rail (fault_rail),
        .state      (state)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete, vectors=%0d", n_vec);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: dut=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic go_fault(input int r);
        m_state = S_FAULT;
        m_frail = r;
        m_fault = 1'b1;
        m_age   = 0;
        m_on    = 0;
    endtask

    task automatic model_step();
        int acc, bad, mask;
        if (reset) begin
            m_state = S_OFF; m_on = 0; m_age = 0; m_frail = 0; m_retries = 0; m_fault = 1'b0;
            for (int i = 0; i < N; i++) begin
                m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_fpg[i] = 1'b0; m_hist[i] = 0;
            end
            return;
        end
        acc = (m_state == S_RU) ? m_on - 1 : (m_state == S_SE) ? m_on : (m_state == S_ON) ? N : 0;
        bad = -1;
        for (int j = acc - 1; j >= 0; j--) if (!m_fpg[j]) bad = j;
        case (m_state)
            S_OFF: begin
                if (enable) begin m_state = S_RU; m_on = 1; m_age = 0; end
                else m_fault = 1'b0;
            end
            S_RU, S_SE, S_ON: begin
                if (bad >= 0) go_fault(bad);
                else if (!enable) begin m_state = S_RD; m_on--; m_age = 0; end
                else if (m_state == S_RU && m_fpg[m_on-1]) begin m_state = S_SE; m_age = 0; end
                else if (m_state == S_RU && m_age == TO - 1) go_fault(m_on - 1);
                else if (m_state == S_SE && m_age == ST - 1) begin
                    if (m_on == N) begin m_state = S_ON; m_fault = 1'b0; m_retries = 0; end
                    else begin m_on++; m_state = S_RU; end
                    m_age = 0;
                end else m_age++;
            end
            S_RD: begin
                if (m_age == OD - 1) begin
                    m_age = 0;
                    if (m_on == 0) m_state = S_OFF;
                    else m_on--;
                end else m_age++;
            end
            default: begin
                if (!enable) begin m_state = S_OFF; m_fault = 1'b0; m_on = 0; end
`ifdef RAIL_SEQ_RETRY_EN
                else if (m_age == RD - 1 && m_retries < MR) begin
                    m_retries++; m_state = S_OFF; m_on = 0;
                end
`endif
                else m_age++;
            end
        endcase
        if (!enable) m_retries = 0;
        mask = (1 << PF) - 1;
        for (int i = 0; i < N; i++) begin
            m_hist[i] = ((m_hist[i] << 1) | int'(m_s2[i])) & 32'hFFFF;
            if ((m_hist[i] & mask) == (m_fpg[i] ? 0 : mask)) m_fpg[i] = !m_fpg[i];
            m_s2[i] = m_s1[i];
            m_s1[i] = pg[i];
        end
    endtask

    task automatic compare();
        int exp_en;
        exp_en = (m_state == S_FAULT) ? 0 : ((1 << m_on) - 1);
        chk("cyc_en",    32'(en),         exp_en);
        chk("cyc_state", 32'(state),      m_state);
        chk("cyc_good",  32'(all_good),   (m_state == S_ON) ? 1 : 0);
        chk("cyc_fault", 32'(fault),      32'(m_fault));
        chk("cyc_rail",  32'(fault_rail), m_frail);
    endtask

    task automatic tick();
        for (int i = 0; i < N; i++) begin
            if (en[i] === 1'b1) b_cnt[i]++; else b_cnt[i] = 0;
            if (b_glitch[i] > 0) begin
                pg[i] = 1'b0;
                b_glitch[i]--;
            end else begin
                pg[i] = (en[i] === 1'b1) && (b_cnt[i] >= b_dly[i]);
            end
        end
        @(posedge sysclk);
        model_step();
        #1;
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int k, ns, r, starts;
        logic [2:0] seen[8];
        logic [2:0] prev;
        logic saw2, prev0;

        reset = 1'b1; enable = 1'b0; pg = '0;
        for (int i = 0; i < N; i++) begin b_cnt[i] = 0; b_dly[i] = 5; b_glitch[i] = 0; end
        tick(); tick();
        chk("rst_state", 32'(state), 32'h0);
        chk("rst_en",    32'(en),    32'h0);
        chk("rst_fault", 32'(fault), 32'h0);
        chk("rst_rail",  32'(fault_rail), 32'h0);
        reset = 1'b0;
        tick();

        // Normal power-up: 13 cycles per rail, ON on the 40th edge.
        enable = 1'b1; ns = 0; prev = en; k = 0;
        while (state !== 4'd3 && k < 300) begin
            tick(); k++;
            if (en !== prev) begin
                if (ns < 8) seen[ns] = en;
                ns++; prev = en;
            end
        end
        chk("up_cycles", k, 40);
        chk("up_nchg", ns, 3);
        chk("up_seq0", 32'(seen[0]), 32'h1);
        chk("up_seq1", 32'(seen[1]), 32'h3);
        chk("up_seq2", 32'(seen[2]), 32'h7);
        chk("on_good", 32'(all_good), 32'h1);
        chk("on_fault", 32'(fault), 32'h0);

        // Normal power-down.
        enable = 1'b0;
        tick();
        chk("dn_en0", 32'(en), 32'h3);
        chk("dn_state", 32'(state), 32'h4);
        idle(3); chk("dn_en1", 32'(en), 32'h1);
        idle(3); chk("dn_en2", 32'(en), 32'h0);
        idle(3); chk("dn_off", 32'(state), 32'h0);
        idle(6);

        // Ramp timeout on rail 1.
        b_dly[1] = 1000; enable = 1'b1; k = 0;
        while (en !== 3'b011 && k < 100) begin tick(); k++; end
        chk("to_en1", 32'(en), 32'h3);
        idle(19);
        chk("to_pre", 32'(state), 32'h1);
        tick();
        chk("to_state", 32'(state), 32'h5);
        chk("to_en", 32'(en), 32'h0);
        chk("to_fault", 32'(fault), 32'h1);
        chk("to_rail", 32'(fault_rail), 32'h1);
        enable = 1'b0;
        tick();
        chk("fx_state", 32'(state), 32'h0);
        chk("fx_fault", 32'(fault), 32'h0);
        chk("fx_rail", 32'(fault_rail), 32'h1);
        b_dly[1] = 5;
        idle(6);

        // pg loss in ON: 1-cycle glitch ignored, 4-cycle loss faults 5 edges later.
        enable = 1'b1; k = 0;
        while (state !== 4'd3 && k < 100) begin tick(); k++; end
        b_glitch[0] = 1;
        idle(6);
        chk("glitch_ign", 32'(state), 32'h3);
        b_glitch[0] = 4; k = 0; prev = en;
        while (state !== 4'd5 && k < 20) begin prev = en; tick(); k++; end
        chk("loss_cycles", k, 5);
        chk("loss_rail", 32'(fault_rail), 32'h0);
        chk("loss_en", 32'(en), 32'h0);
        chk("loss_prev_en", 32'(prev), 32'h7);
        enable = 1'b0;
        tick();
        idle(6);

        // enable drop during SETTLE of rail 1.
        enable = 1'b1; k = 0; saw2 = 1'b0;
        while (!(state === 4'd2 && en === 3'b011) && k < 100) begin tick(); k++; saw2 |= en[2]; end
        enable = 1'b0;
        tick(); saw2 |= en[2];
        chk("md_state", 32'(state), 32'h4);
        chk("md_en", 32'(en), 32'h1);
        for (int i = 0; i < 3; i++) begin tick(); saw2 |= en[2]; end
        chk("md_en0", 32'(en), 32'h0);
        for (int i = 0; i < 3; i++) begin tick(); saw2 |= en[2]; end
        chk("md_off", 32'(state), 32'h0);
        chk("md_no_rail2", 32'(saw2), 32'h0);
        idle(6);

        // Reset during SETTLE.
        enable = 1'b1; k = 0;
        while (state !== 4'd2 && k < 100) begin tick(); k++; end
        reset = 1'b1;
        tick();
        chk("rs_en", 32'(en), 32'h0);
        chk("rs_state", 32'(state), 32'h0);
        reset = 1'b0; enable = 1'b0;
        idle(6);

`ifdef RAIL_SEQ_RETRY_EN
        b_dly[0] = 1000; enable = 1'b1; starts = 0; prev0 = en[0];
        for (int i = 0; i < 200; i++) begin
            tick();
            if (en[0] === 1'b1 && prev0 !== 1'b1) starts++;
            prev0 = en[0];
        end
        chk("retry_starts", starts, 3);
        chk("retry_state", 32'(state), 32'h5);
        chk("retry_fault", 32'(fault), 32'h1);
        enable = 1'b0;
        tick();
        b_dly[0] = 5;
        idle(6);
`else
        starts = 0; prev0 = 1'b0;
`endif

        for (int c = 0; c < 3000; c++) begin
            if (enable) begin
                if ($urandom_range(0, 119) == 0) enable = 1'b0;
            end else begin
                if ($urandom_range(0, 19) == 0) enable = 1'b1;
            end
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) begin
                r = $urandom_range(0, N - 1);
                b_glitch[r] = $urandom_range(1, 4);
            end
            if ($urandom_range(0, 49) == 0) begin
                r = $urandom_range(0, N - 1);
                b_dly[r] = $urandom_range(1, 24);
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
